// File: rtl/lsu_if.sv
// CPU-request and DMEM signal bundle for load_store_unit.
// slave = the LSU itself; master = the CPU and DMEM side that drives requests and read data.
interface lsu_if;
  // Handshake: req is sampled only while busy=0, and every accepted request ends with
  // exactly one done pulse. There is no back-pressure, and a req seen while busy is dropped.
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        dm_ena;
  logic        dm_write;
  logic        dm_read;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [2:0]  dbg_state;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, dm_rdata,
    output busy, done, err, rdata, dm_ena, dm_write, dm_read, dm_addr, dm_wdata, dbg_state
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, dm_rdata,
    input  busy, done, err, rdata, dm_ena, dm_write, dm_read, dm_addr, dm_wdata, dbg_state
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit with byte/half read-modify-write onto a word-wide DMEM.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses trap with err; otherwise they are force-aligned.
module load_store_unit (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_ext_q, sign_ext_d;
    logic [12:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        err_q, err_d;
`endif

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
    endfunction

    function automatic logic [12:0] align_addr(input logic [12:0] a, input logic [1:0] sz);
        logic [12:0] r;
        r = a;
        if (sz == 2'b01) r[0] = 1'b0;
        else if (sz[1])  r[1:0] = 2'b00;
        return r;
    endfunction

    // Replace only the addressed lane(s); every other bit keeps the word just read.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_w, input logic [31:0] new_d,
                                               input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] m;
        m = old_w;
        if (sz == 2'b00)      m[{lane, 3'b000} +: 8] = new_d[7:0];
        else if (sz == 2'b01) m[{lane[1], 4'b0000} +: 16] = new_d[15:0];
        else                  m = new_d;
        return m;
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic sx, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_ext_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sign_ext_q <= sign_ext_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        sign_ext_d = sign_ext_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d       = bus.we;
                    size_d     = bus.size;
                    sign_ext_d = bus.sign_ext;
                    data_d     = bus.wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                    addr_d     = bus.addr[12:0];
                    err_d      = misaligned(bus.size, bus.addr[1:0]);
                    if (misaligned(bus.size, bus.addr[1:0])) state_d = S_RESP;
                    else
`else
                    addr_d     = align_addr(bus.addr[12:0], bus.size);
`endif
                    if (!bus.we)        state_d = S_LOAD;
                    else if (bus.size[1]) state_d = S_STORE;
                    else                state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = extract_lane(bus.dm_rdata, size_q, sign_ext_q, addr_q[1:0]);
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                data_d  = merge_lane(bus.dm_rdata, data_q, size_q, addr_q[1:0]);
                state_d = S_STORE;
            end
            S_STORE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // DMEM strobes depend on state alone so reset can cut off a pending write cleanly.
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_RESP);
`ifdef LSU_MISALIGN_TRAP_EN
        bus.err       = (state_q == S_RESP) && err_q;
`else
        bus.err       = 1'b0;
`endif
        bus.rdata     = rdata_q;
        bus.dm_ena    = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_STORE);
        bus.dm_read   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
        bus.dm_write  = (state_q == S_STORE);
        bus.dm_addr   = addr_q[12:2];
        bus.dm_wdata  = (state_q == S_STORE) ? data_q : 32'h0;
        bus.dbg_state = state_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts latency, rdata and
// memory contents; a per-cycle compare process and a DMEM-side monitor check the DUT against it.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  lsu_if bus();

  load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] dmem    [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = -100;
  int done_cyc = -100;
  logic exp_err_f = 1'b0;
  logic exp_load = 1'b0;
  logic [31:0] model_rdata = 32'h0;
  logic [10:0] exp_widx = 11'h0;
  logic [31:0] exp_wword = 32'h0;
  int ena_cnt = 0;
  int wr_cnt = 0;
  bit rst_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  assign bus.dm_rdata = dmem[bus.dm_addr];

  // DMEM: write on the falling edge, plus strobe monitoring.
  always @(negedge clk) begin
    if (bus.dm_ena) begin
      ena_cnt++;
      chk("dm_addr", {21'h0, bus.dm_addr}, {21'h0, exp_widx});
    end
    if (bus.dm_write) begin
      wr_cnt++;
      chk("dm_wdata", bus.dm_wdata, exp_wword);
      dmem[bus.dm_addr] = bus.dm_wdata;
    end else begin
      chk("dm_wdata_idle", bus.dm_wdata, 32'h0);
    end
  end

  // Per-cycle compare against the transaction model.
  always @(posedge clk) begin
    rst_seen = rst;
    cyc++;
    #1;
    if (rst_seen) begin
      acc_cyc = -100;
      done_cyc = -100;
      model_rdata = 32'h0;
      exp_q.delete();
    end else if (cyc == done_cyc && exp_load) begin
      if (exp_q.size() > 0) model_rdata = exp_q.pop_front();
    end
    chk("done",  {31'h0, bus.done}, {31'h0, (cyc == done_cyc)});
    chk("busy",  {31'h0, bus.busy}, {31'h0, (cyc >= acc_cyc && cyc <= done_cyc)});
    chk("err",   {31'h0, bus.err},  {31'h0, (cyc == done_cyc) && exp_err_f});
    chk("rdata", bus.rdata, model_rdata);
  end

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit busy_pulse, input bit rst_in_rmw);
    int lat, k, ena_e, wr_e;
    logic trap;
    logic [31:0] ea, oldw, neww, rd, mask;
    logic [10:0] wi;
    @(posedge clk); #2;
    wi = a[12:2];
    ea = a;
    if (sz == 2'b01) ea[0] = 1'b0;
    else if (sz[1]) ea[1:0] = 2'b00;
    k = int'(ea[1:0]);
    oldw = ref_mem[wi];
    neww = oldw;
    rd = 32'h0;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
    if (trap) begin
      lat = 1; ena_e = 0; wr_e = 0;
    end else if (!w) begin
      lat = 2; ena_e = 1; wr_e = 0;
      if (sz == 2'b00) begin
        rd = (oldw >> (8 * k)) & 32'hFF;
        if (sx && rd[7]) rd = rd | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        rd = (oldw >> (8 * k)) & 32'hFFFF;
        if (sx && rd[15]) rd = rd | 32'hFFFF_0000;
      end else begin
        rd = oldw;
      end
    end else if (sz[1]) begin
      lat = 2; ena_e = 1; wr_e = 1;
      neww = wd;
    end else begin
      lat = 3; ena_e = 2; wr_e = 1;
      mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << (8 * k);
      neww = (oldw & ~mask) | ((wd << (8 * k)) & mask);
    end
    exp_widx = wi;
    exp_wword = neww;
    exp_err_f = trap;
    exp_load = !w && !trap;
    if (exp_load) exp_q.push_back(rd);
    acc_cyc = cyc + 1;
    done_cyc = cyc + lat;
    ena_cnt = 0;
    wr_cnt = 0;
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #2;
    bus.req = 1'b0;
    bus.addr = 32'h0000_1FFC; bus.wdata = 32'h0BAD_0BAD; bus.we = 1'b1; bus.size = 2'b10;
    if (rst_in_rmw) begin
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("abort_ena_cnt", ena_cnt, 1);
      chk("abort_wr_cnt", wr_cnt, 0);
      chk("abort_mem", dmem[wi], ref_mem[wi]);
      return;
    end
    for (int i = 1; i < lat; i++) begin
      bus.req = (busy_pulse && i == 1);
      @(posedge clk); #2;
      bus.req = 1'b0;
    end
    if (w && !trap) ref_mem[wi] = neww;
    chk("ena_cnt", ena_cnt, ena_e);
    chk("wr_cnt", wr_cnt, wr_e);
    chk("mem_word", dmem[wi], ref_mem[wi]);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0;
    for (int i = 0; i < 2048; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    dmem[5] = 32'h8844_22F1; ref_mem[5] = 32'h8844_22F1;
    dmem[3] = 32'h1122_3344; ref_mem[3] = 32'h1122_3344;
    dmem[1] = 32'hCAFE_0001; ref_mem[1] = 32'hCAFE_0001;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_dm", {bus.dm_ena, bus.dm_write, bus.dm_read, bus.dm_addr}, 32'h0);

    access(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 0, 0);
    chk("lit_lb_15", bus.rdata, 32'h0000_0022);
    chk("pin_lb_15", model_rdata, 32'h0000_0022);
    access(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 0, 0);
    chk("lit_lb_14", bus.rdata, 32'hFFFF_FFF1);
    access(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 0, 0);
    chk("lit_lhu_16", bus.rdata, 32'h0000_8844);
    access(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 0, 0);
    chk("lit_lh_16", bus.rdata, 32'hFFFF_8844);
    chk("pin_lh_16", model_rdata, 32'hFFFF_8844);
    access(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 0, 0);
    chk("lit_lbu_17", bus.rdata, 32'h0000_0088);
    access(1'b0, 2'b11, 1'b1, 32'h14, 32'h0, 0, 0);
    chk("lit_lw11_14", bus.rdata, 32'h8844_22F1);

    access(1'b1, 2'b00, 1'b0, 32'h0E, 32'h0000_00AB, 0, 0);
    chk("lit_sb_0e", dmem[3], 32'h11AB_3344);
    chk("pin_sb_0e", ref_mem[3], 32'h11AB_3344);
    chk("store_keeps_rdata", bus.rdata, 32'h8844_22F1);

    access(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 1, 0);
    chk("lit_sw_20", dmem[8], 32'hDEAD_BEEF);
    chk("lit_sw_ign", dmem[11'h7FF], ref_mem[11'h7FF]);

    access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lit_trap_rdata", bus.rdata, 32'h8844_22F1);
`else
    chk("lit_lw_22", bus.rdata, 32'hDEAD_BEEF);
`endif

    access(1'b1, 2'b01, 1'b0, 32'h04, 32'h0000_5566, 0, 1);
    chk("lit_abort_w1", dmem[1], 32'hCAFE_0001);
    chk("lit_abort_rdata", bus.rdata, 32'h0);

    access(1'b1, 2'b01, 1'b0, 32'h06, 32'h0000_5566, 0, 0);
    chk("lit_sh_06", dmem[1], 32'h5566_0001);
    access(1'b1, 2'b01, 1'b0, 32'h05, 32'h0000_1234, 0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lit_sh_05", dmem[1], 32'h5566_1234);
`endif
    access(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 0, 0);
    chk("lit_lh_06", bus.rdata, 32'h0000_5566);
    access(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 0, 0);
    access(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF7E, 0, 0);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, 0);
    chk("pin_sb_lb_11", model_rdata, 32'h0000_007E);

    repeat (4) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req  input  1  access request from CPU; sampled only in IDLE.
REQ-004 we  input  1  1 = store, 0 = load.
REQ-005 size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-006 sign_ext  input  1  loads: 1 sign-extend, 0 zero-extend; ignored for word and store.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  one-cycle misalignment pulse, coincident with done.
REQ-012 rdata  output  32  load result, extended; held until next done.
REQ-013 dm_ena, dm_write, dm_read  output  1 each  DMEM strobes.
REQ-014 dm_addr  output  11  DMEM word index = latched addr[12:2].
REQ-015 dm_wdata  output  32  DMEM write word; 0 outside STORE state.
REQ-016 dm_rdata  input  32  DMEM combinational read word.

Function
REQ-017 States IDLE, LOAD, RMW_RD, STORE, RESP; DMEM strobes decoded from state only.
REQ-018 IDLE: on req=1, latch we/size/sign_ext/addr/wdata; req while busy is ignored (no queueing).
REQ-019 Accepted aligned load -> LOAD (dm_ena=1, dm_read=1) -> RESP; done at accept+2 cycles.
REQ-020 Accepted word store -> STORE (dm_ena=1, dm_write=1, dm_wdata=wdata) -> RESP; done at accept+2.
REQ-021 Accepted byte/half store -> RMW_RD (read, capture dm_rdata) -> STORE (merged word) -> RESP; done at accept+3.
REQ-022 Little-endian lanes: byte k of word = bits [8k+7:8k], k = addr[1:0]; half at addr[1]=0 is [15:0], addr[1]=1 is [31:16].
REQ-023 RMW merge replaces only addressed lane(s); other bits equal captured dm_rdata.
REQ-024 Load extract: selected lane right-aligned; upper bits = lane MSB if sign_ext else 0; word returned unchanged.
REQ-025 rdata updates only on completion of a load; stores and errors leave rdata unchanged.
REQ-026 RESP: done=1 one cycle, then IDLE; new req accepted in the cycle after RESP.
REQ-027 Misaligned = half with addr[0]=1, or word with addr[1:0]!=0; handling per REQ-032/033.
REQ-028 Write occurs at DMEM's falling edge inside STORE; a store issues exactly one dm_write cycle.

Reset
REQ-029 rst=1 at rising edge: state IDLE; busy, done, err, rdata, dm_* outputs = 0; latched fields = 0.
REQ-030 Reset mid-operation abandons the access; reset sampled during RMW_RD prevents the write; STORE cycle already entered completes its falling-edge write.
REQ-031 No done pulse for an abandoned access.

Configuration
REQ-032 LSU_MISALIGN_TRAP_EN defined: misaligned request goes IDLE -> RESP directly, done=1 and err=1 at accept+1, no DMEM strobe, rdata unchanged.
REQ-033 LSU_MISALIGN_TRAP_EN undefined: low address bits forced aligned (half ignores addr[0], word ignores addr[1:0]), access proceeds normally, err tied 0.

Verification
REQ-034 Preload word 5 = 0x8844_22F1; load byte addr 0x15 sign_ext=1 -> rdata 0x0000_0022 (lane1), addr 0x14 sign_ext=1 -> 0xFFFF_FFF1, done 2 cycles after req.
REQ-035 Word 5 = 0x8844_22F1; load half addr 0x16 sign_ext=0 -> 0x0000_8844; sign_ext=1 -> 0xFFFF_8844.
REQ-036 Word 3 = 0x1122_3344; store byte 0xAB at addr 0x0E -> word 3 = 0x11AB_3344, done at req+3, exactly one dm_write cycle.
REQ-037 Store word 0xDEAD_BEEF at addr 0x20 -> word 8 = 0xDEAD_BEEF, done at req+2; req pulse during busy ignored.
REQ-038 With LSU_MISALIGN_TRAP_EN: load word addr 0x22 -> done=1, err=1 at req+1, dm_ena never high; without: reads word 8.
REQ-039 Store half 0x5566 at addr 0x04, rst=1 during RMW_RD -> IDLE, no write, word 1 unchanged, no done.
